led_page_scanner: RTL and testbench
===================================

// Module: led_page_scanner
// PURPOSE
//  Parametrised N-channel LED page display for board bring-up (RDID/ID bytes, status words).
//  Each channel's data is latched on its valid strobe into a shadow register.
//  One channel is shown on the LEDs: either selected by debounced switches (MANUAL)
//  or stepped automatically on a dwell timer (AUTO).
//  Sits between the SPI/flash command engines and the board LED pins.
// PARAMETERS
//  NUM_CH          4           number of source channels (>=2)
//  WIDTH           8           bits per channel = LED count
//  SEL_W           2           switch select width; must satisfy 2**SEL_W >= NUM_CH
//  DWELL_CYCLES    50_000_000  clk cycles each channel is shown in AUTO (>=2)
//  DEBOUNCE_CYCLES 1_000_000   cycles a synchronised switch must be stable before it is accepted (>=1)
//  DEFAULT_PATTERN 8'hFF       WIDTH-bit value shown for out-of-range or never-captured channels
// PORTS
//  clk      in   1             system clock; the block has one clock domain
//  rst      in   1             synchronous, active-high reset
//  sw_sel   in   SEL_W         raw channel-select switches; asynchronous to clk
//  sw_auto  in   1             raw mode switch; asynchronous (1 = AUTO)
//  ch_data  in   NUM_CH*WIDTH  packed channel data; channel k = [k*WIDTH +: WIDTH]
//  ch_valid in   NUM_CH        1-cycle capture strobe per channel
//  led      out  WIDTH         registered LED drive
//  cur_ch   out  SEL_W         channel currently displayed (registered)
//  auto_on  out  1             1 while the FSM is in AUTO
// BEHAVIOUR
//  Reset: led=DEFAULT_PATTERN, cur_ch=0, auto_on=0, state=MANUAL.
//    Reset also clears all shadows, captured flags, the dwell counter and debounce state
//    (debounced switch values = 0).
//  Reset mid-operation behaves identically to power-up; pending captures are lost.
//  Input synchroniser: each switch bit passes a 2-FF synchroniser.
//  Debounce, per bit:
//   - a counter counts consecutive cycles where the synchronised value != accepted value;
//   - when it reaches DEBOUNCE_CYCLES, the accepted value updates;
//   - any bounce back resets the counter to 0.
//  Capture:
//   - ch_valid[k]=1 at edge E loads shadow[k]=ch_data[k] and sets captured[k].
//   - Any combination of strobes captures in the same cycle.
//   - Captures are independent of mode.
//  Display value for channel c:
//   - shadow[c] if c<NUM_CH and captured[c]=1;
//   - otherwise DEFAULT_PATTERN.
//   - led/cur_ch register this value: led reflects a shadow update one cycle after the capture edge.
//  Switch latency: raw change to led change is exactly 2 + DEBOUNCE_CYCLES + 1 cycles.
//  FSM, states MANUAL and AUTO:
//   - MANUAL: cur_ch = debounced sw_sel. A value >= NUM_CH is shown as DEFAULT_PATTERN
//     and cur_ch still reports it.
//   - MANUAL -> AUTO on debounced sw_auto=1: cur_ch<=0, dwell counter<=0.
//   - AUTO: the dwell counter increments each cycle. At DWELL_CYCLES-1 the counter wraps to 0
//     and cur_ch advances; NUM_CH-1 wraps to 0. cur_ch never holds a value >= NUM_CH.
//   - AUTO -> MANUAL on debounced sw_auto=0: the next cycle shows the debounced sw_sel;
//     the dwell counter clears.
//   - In AUTO, debounced sw_sel changes are tracked but ignored.
//   - Same-cycle mode change and dwell expiry: the mode change wins.
//  Width rules:
//   - dwell counter width = $clog2(DWELL_CYCLES); debounce counter width = $clog2(DEBOUNCE_CYCLES+1).
//   - No truncation of the parameter compare.
// STRUCTURE
//  Package led_scan_pkg:
//   - typedef enum {MANUAL, AUTO} scan_state_t;
//   - localparam DEFAULT_PATTERN_8 = 8'hFF.
//  Sub-module switch_debounce (#(CYCLES)):
//   - 2-FF synchroniser + stability counter, 1-bit;
//   - one instance per bit, SEL_W+1 instances via generate.
//  Top-level contents: shadow/captured array, FSM, dwell counter, output register.
// TESTING  (NUM_CH=4, WIDTH=8, DWELL_CYCLES=4, DEBOUNCE_CYCLES=3)
//  1. Release rst, no strobes -> led=8'hFF, cur_ch=0, auto_on=0 every cycle.
//  2. ch_valid=4'b0101 with ch0=8'h20, ch2=8'hEF (same cycle); sw_sel=2 held -> led=8'hEF
//     exactly 6 cycles after the sw_sel change. Then sw_sel=0 -> led=8'h20; sw_sel=1 -> led=8'hFF.
//  3. sw_sel toggles 0->1->0 with 2-cycle pulses -> debounced value never changes; led constant.
//  4. Load ch0..3 = 8'hC2, 8'h20, 8'h18, 8'h77; sw_auto=1 -> auto_on rises; cur_ch sequence
//     0,1,2,3,0 with each value held exactly 4 cycles; led tracks it.
//  5. In AUTO, ch_valid[2] with 8'h55 while ch2 is displayed -> led=8'h55 on the cycle after capture.
//     Drop sw_auto -> MANUAL; cur_ch = debounced sw_sel.
//  6. Assert rst during AUTO with cur_ch=2 -> next cycle led=8'hFF, cur_ch=0, auto_on=0,
//     all captured flags cleared.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED page scanner.
package led_scan_pkg;

    // Display mode: switch-selected page or timed rotation through all pages.
    typedef enum logic {
        MANUAL,
        AUTO
    } scan_state_t;

    localparam logic [7:0] DEFAULT_PATTERN_8 = 8'hFF;

endpackage

// File: rtl/switch_debounce.sv
// One-bit switch conditioner: 2-FF synchroniser followed by a stability counter.
// The accepted value follows the synchronised input only after it has differed
// from the accepted value for CYCLES consecutive clocks.
module switch_debounce #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CntW = $clog2(CYCLES + 1);
    // Acceptance happens on the clock that would take the count to CYCLES.
    localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);

    logic            meta_q;
    logic            sync_q;
    logic            acc_q;
    logic [CntW-1:0] cnt_q;

    // Bring the asynchronous switch into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Count consecutive disagreeing cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else if (sync_q == acc_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
            acc_q <= sync_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign stable = acc_q;

endmodule

// File: rtl/led_page_scanner.sv
// N-channel LED page display: per-channel shadow capture, debounced manual
// selection or timed automatic rotation, registered LED and channel outputs.
module led_page_scanner
    import led_scan_pkg::*;
#(
    parameter int unsigned      NUM_CH          = 4,
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      SEL_W           = 2,
    parameter int unsigned      DWELL_CYCLES    = 50_000_000,
    parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [WIDTH-1:0] DEFAULT_PATTERN = DEFAULT_PATTERN_8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sw_sel,
    input  logic                    sw_auto,
    input  logic [NUM_CH*WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]       ch_valid,
    output logic [WIDTH-1:0]        led,
    output logic [SEL_W-1:0]        cur_ch,
    output logic                    auto_on
);

    localparam int unsigned       DwellW    = $clog2(DWELL_CYCLES);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0]  ChLast    = SEL_W'(NUM_CH - 1);

    // Switch conditioning: bit SEL_W is the mode switch, the rest select the page.
    logic [SEL_W:0] sw_raw;
    logic [SEL_W:0] sw_deb;

    assign sw_raw = {sw_auto, sw_sel};

    for (genvar i = 0; i <= SEL_W; i++) begin : g_deb
        switch_debounce #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_raw[i]),
            .stable(sw_deb[i])
        );
    end

    logic [SEL_W-1:0] deb_sel;
    logic             deb_auto;

    assign deb_sel  = sw_deb[SEL_W-1:0];
    assign deb_auto = sw_deb[SEL_W];

    // Shadow registers and captured flags; any mix of strobes loads together.
    logic [WIDTH-1:0]  shadow_q [NUM_CH];
    logic [NUM_CH-1:0] captured_q;

    // Latch each channel on its strobe, independent of display mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= '0;
            end
            captured_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid[k]) begin
                    shadow_q[k]   <= ch_data[k*WIDTH +: WIDTH];
                    captured_q[k] <= 1'b1;
                end
            end
        end
    end

    scan_state_t       state_q, state_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
    logic [WIDTH-1:0]  led_q, led_d;
    logic              auto_on_q;

    // Next mode, dwell count and displayed channel; a mode change beats dwell expiry.
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        cur_ch_d = cur_ch_q;
        unique case (state_q)
            MANUAL: begin
                if (deb_auto) begin
                    state_d  = AUTO;
                    dwell_d  = '0;
                    cur_ch_d = '0;
                end else begin
                    cur_ch_d = deb_sel;
                end
            end
            AUTO: begin
                if (!deb_auto) begin
                    state_d  = MANUAL;
                    dwell_d  = '0;
                    cur_ch_d = deb_sel;
                end else if (dwell_q == DwellLast) begin
                    dwell_d  = '0;
                    cur_ch_d = (cur_ch_q == ChLast) ? '0 : cur_ch_q + SEL_W'(1);
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    // Page value for the channel about to be shown; uncaptured or out-of-range gives the default.
    always_comb begin
        led_d = DEFAULT_PATTERN;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch_d == SEL_W'(k) && captured_q[k]) begin
                led_d = shadow_q[k];
            end
        end
    end

    // Mode FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MANUAL;
            dwell_q   <= '0;
            cur_ch_q  <= '0;
            led_q     <= DEFAULT_PATTERN;
            auto_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            cur_ch_q  <= cur_ch_d;
            led_q     <= led_d;
            auto_on_q <= (state_d == AUTO);
        end
    end

    assign led     = led_q;
    assign cur_ch  = cur_ch_q;
    assign auto_on = auto_on_q;

endmodule

// File: tb/tb_led_page_scanner.sv
// Self-checking bench for led_page_scanner: directed scenarios with literal
// expectations plus a randomized phase against a cycle-level reference model.
module tb_led_page_scanner;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int SEL_W  = 2;
    localparam int DWELL  = 4;
    localparam int DEB    = 3;

    logic                    clk;
    logic                    rst;
    logic [SEL_W-1:0]        sw_sel;
    logic                    sw_auto;
    logic [NUM_CH*WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_valid;
    logic [WIDTH-1:0]        led;
    logic [SEL_W-1:0]        cur_ch;
    logic                    auto_on;

    int checks   = 0;
    int failures = 0;

    led_page_scanner #(
        .NUM_CH         (NUM_CH),
        .WIDTH          (WIDTH),
        .SEL_W          (SEL_W),
        .DWELL_CYCLES   (DWELL),
        .DEBOUNCE_CYCLES(DEB),
        .DEFAULT_PATTERN(8'hFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_sel  (sw_sel),
        .sw_auto (sw_auto),
        .ch_data (ch_data),
        .ch_valid(ch_valid),
        .led     (led),
        .cur_ch  (cur_ch),
        .auto_on (auto_on)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw switch samples, newest first. A switch is accepted once its value two
    // clocks back (after synchronisation) has disagreed with the accepted value
    // for DEB consecutive clocks. AUTO page = elapsed clocks since entry / DWELL.
    logic [SEL_W:0]   m_hist [DEB+2];
    logic [SEL_W:0]   m_acc;
    logic [WIDTH-1:0] m_shadow [NUM_CH];
    bit               m_capt [NUM_CH];
    bit               m_mode;
    int               m_n, m_t0, m_cur;
    logic [WIDTH-1:0] m_led;
    bit               m_ready = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEB + 2; j++) m_hist[j] = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_shadow[k] = '0;
                m_capt[k]   = 1'b0;
            end
            m_acc   = '0;
            m_mode  = 1'b0;
            m_cur   = 0;
            m_led   = 8'hFF;
            m_n     = 0;
            m_t0    = 0;
            m_ready = 1'b1;
        end else begin
            m_n++;
            if (!m_mode && m_acc[SEL_W]) begin
                m_mode = 1'b1;
                m_t0   = m_n;
            end else if (m_mode && !m_acc[SEL_W]) begin
                m_mode = 1'b0;
            end
            m_cur = m_mode ? ((m_n - m_t0) / DWELL) % NUM_CH : int'(m_acc[SEL_W-1:0]);
            m_led = (m_cur < NUM_CH && m_capt[m_cur]) ? m_shadow[m_cur] : 8'hFF;
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid[k]) begin
                    m_shadow[k] = ch_data[k*WIDTH +: WIDTH];
                    m_capt[k]   = 1'b1;
                end
            end
            for (int j = DEB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = {sw_auto, sw_sel};
            for (int b = 0; b <= SEL_W; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 2; j < DEB + 2; j++) begin
                    if (m_hist[j][b] == m_acc[b]) all_diff = 1'b0;
                end
                if (all_diff) m_acc[b] = ~m_acc[b];
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            check("model_led", int'(led), int'(m_led));
            check("model_cur_ch", int'(cur_ch), m_cur);
            check("model_auto_on", int'(auto_on), int'(m_mode));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic expect_out(input string name, input int e_led, input int e_cur,
                              input int e_auto);
        check({name, "_led"}, int'(led), e_led);
        check({name, "_cur_ch"}, int'(cur_ch), e_cur);
        check({name, "_auto_on"}, int'(auto_on), e_auto);
    endtask

    logic [7:0] page_tbl [NUM_CH];

    initial begin
        rst      = 1'b1;
        sw_sel   = '0;
        sw_auto  = 1'b0;
        ch_data  = '0;
        ch_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            expect_out("t1_idle", 8'hFF, 0, 0);
        end
        check("t1_model_pin", int'(m_led), 8'hFF);

        // 2: simultaneous capture of ch0/ch2, select ch2
        ch_valid = 4'b0101;
        ch_data  = {8'h00, 8'hEF, 8'h00, 8'h20};
        sw_sel   = 2'd2;
        @(negedge clk);
        ch_valid = '0;
        repeat (4) @(negedge clk);
        check("t2_before_latency", int'(led), 8'h20);
        @(negedge clk);
        check("t2_sel2_led", int'(led), 8'hEF);
        check("t2_sel2_cur", int'(cur_ch), 2);
        check("t2_model_pin", int'(m_led), 8'hEF);
        sw_sel = 2'd0;
        repeat (5) @(negedge clk);
        check("t2_sel0_hold", int'(led), 8'hEF);
        @(negedge clk);
        check("t2_sel0_led", int'(led), 8'h20);
        sw_sel = 2'd1;
        repeat (6) @(negedge clk);
        check("t2_sel1_led", int'(led), 8'hFF);
        check("t2_sel1_cur", int'(cur_ch), 1);

        // 3: short bounces never get through the debouncer
        sw_sel = 2'd0;
        repeat (8) @(negedge clk);
        check("t3_settled", int'(led), 8'h20);
        for (int p = 0; p < 4; p++) begin
            sw_sel = (p % 2 == 0) ? 2'd1 : 2'd0;
            repeat (2) begin
                @(negedge clk);
                check("t3_bounce_led", int'(led), 8'h20);
            end
        end
        repeat (8) begin
            @(negedge clk);
            expect_out("t3_after", 8'h20, 0, 0);
        end

        // 4: AUTO rotation over four captured pages
        page_tbl[0] = 8'hC2;
        page_tbl[1] = 8'h20;
        page_tbl[2] = 8'h18;
        page_tbl[3] = 8'h77;
        ch_valid = 4'b1111;
        ch_data  = {8'h77, 8'h18, 8'h20, 8'hC2};
        @(negedge clk);
        ch_valid = '0;
        sw_auto  = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_auto_latency", int'(auto_on), 0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            expect_out("t4_rotate", int'(page_tbl[(i / 4) % 4]), (i / 4) % 4, 1);
            @(negedge clk);
        end

        // 5: capture into the displayed page while in AUTO, then back to MANUAL
        begin
            int guard;
            guard = 0;
            while (cur_ch != 2'd2 && guard < 12) begin
                @(negedge clk);
                guard++;
            end
            check("t5_reach_ch2", int'(cur_ch), 2);
        end
        ch_valid = 4'b0100;
        ch_data  = {8'h00, 8'h55, 8'h00, 8'h00};
        @(negedge clk);
        ch_valid = '0;
        @(negedge clk);
        expect_out("t5_live_update", 8'h55, 2, 1);
        sw_sel  = 2'd3;
        sw_auto = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_manual_latency", int'(auto_on), 1);
        @(negedge clk);
        expect_out("t5_manual", 8'h77, 3, 0);

        // 6: reset in the middle of AUTO rotation
        sw_auto = 1'b1;
        begin
            int guard;
            guard = 0;
            while (!(auto_on && cur_ch == 2'd2) && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            check("t6_reach_auto_ch2", int'(auto_on && cur_ch == 2'd2), 1);
        end
        rst     = 1'b1;
        sw_auto = 1'b0;
        @(negedge clk);
        expect_out("t6_reset", 8'hFF, 0, 0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            expect_out("t6_cleared", 8'hFF, 0, 0);
        end
        @(negedge clk);
        expect_out("t6_sel3_uncaptured", 8'hFF, 3, 0);

        // Randomized phase: model comparison runs every cycle.
        for (int c = 0; c < 3000; c++) begin
            ch_valid = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            ch_data  = $urandom;
            if ($urandom_range(0, 15) == 0) sw_sel = SEL_W'($urandom);
            if ($urandom_range(0, 59) == 0) sw_auto = ~sw_auto;
            rst = ($urandom_range(0, 699) == 0);
            @(negedge clk);
        end
        rst      = 1'b0;
        ch_valid = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
